// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the PWM generator / meter pair.
//   CNT_W_DEF   default width of the meter counters and result registers
//   CNT_MAX     saturation value of a CNT_W_DEF-wide counter
//   GEN_PERIOD  period of the companion PWM generator, in clk cycles
//   meter_state_t  meter FSM states
package pwm_pkg;

  localparam int unsigned CNT_W_DEF  = 8;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};
  localparam int unsigned GEN_PERIOD = 64;

  typedef enum logic {
    ARMED   = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser for an asynchronous input plus a
// rising-edge detector on the synchronised level.
//   clk, reset  clock, synchronous active-high reset
//   d           asynchronous input
//   s           synchronised level (last synchroniser stage)
//   rise        one-cycle pulse: s high now, low the cycle before
// SYNC_STAGES must be at least 2.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      s_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev;

endmodule

// File: rtl/pwm_meter.sv
// pwm_meter: measures high time and period of a PWM input in clk cycles,
// both counted between consecutive rising edges of the synchronised input.
//   clk, reset  clock, synchronous active-high reset
//   pwm_in      asynchronous PWM input
//   sel         0 = high time, 1 = period on meas
//   meas        selected result register (combinational mux)
//   valid       one-cycle strobe, both result registers just updated
//   stuck       no rising edge within 2^CNT_W-1 cycles
//   level       synchronised input level
//
// state   | meaning
// ARMED   | waiting for a first rising edge; no measurement running
// MEASURE | counting since the last rising edge
module pwm_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  input  logic             sel,
  output logic [CNT_W-1:0] meas,
  output logic             valid,
  output logic             stuck,
  output logic             level
);

  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             s;
  logic             rise;
  meter_state_t     state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .reset(reset),
    .d    (pwm_in),
    .s    (s),
    .rise (rise)
  );

  // Counters start at 1 on a rise because the rise cycle itself is the
  // first cycle of the interval and s is already high in it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARMED;
      period_cnt <= '0;
      high_cnt   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ARMED: begin
          if (rise) begin
            state      <= MEASURE;
            period_cnt <= ONE;
            high_cnt   <= ONE;
            stuck      <= 1'b0;
          end
        end
        MEASURE: begin
          // A rise wins over the timeout when both land on the same cycle.
          if (rise) begin
            period_q   <= period_cnt;
            high_q     <= high_cnt;
            valid      <= 1'b1;
            period_cnt <= ONE;
            high_cnt   <= ONE;
          end else if (period_cnt == SAT) begin
            stuck <= 1'b1;
            state <= ARMED;
          end else begin
            period_cnt <= period_cnt + ONE;
            if (s && (high_cnt != SAT)) begin
              high_cnt <= high_cnt + ONE;
            end
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  assign meas  = sel ? period_q : high_q;
  assign level = s;

endmodule

// File: tb/tb_pwm_meter.sv
module tb_pwm_meter;
  import pwm_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pwm_in = 1'b0;
  logic             sel = 1'b0;
  logic [CNT_W-1:0] meas;
  logic             valid;
  logic             stuck;
  logic             level;

  pwm_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pwm_in(pwm_in),
    .sel   (sel),
    .meas  (meas),
    .valid (valid),
    .stuck (stuck),
    .level (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int p;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   cur_h = 0;
  int   cur_p = 0;
  logic prev_valid = 1'b0;
  logic prev_stuck = 1'b0;
  int   last_valid_cyc = -1;
  int   stuck_rise_cyc = -1;
  bit   have_prev = 1'b0;
  int   prev_h = 0;
  int   prev_p = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
  endtask

  // One clock: drive pwm_in, then after the edge read both result registers
  // through sel and score any valid strobe against the expected queue.
  task automatic tick(input logic v);
    res_t e;
    pwm_in = v;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sel = 1'b0;
    #1 cur_h = int'(meas);
    sel = 1'b1;
    #1 cur_p = int'(meas);
    if (valid) begin
      last_valid_cyc = cyc;
      check("valid_gap", int'(prev_valid), 0);
      check("stuck_at_valid", int'(stuck), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", int'(valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("high_q", cur_h, e.h);
        check("period_q", cur_p, e.p);
      end
    end
    if (stuck && !prev_stuck) stuck_rise_cyc = cyc;
    prev_valid = valid;
    prev_stuck = stuck;
  endtask

  // The previous period is reported when the rise that starts the next one arrives.
  task automatic push_prev();
    if (have_prev) exp_q.push_back('{prev_h, prev_p});
    have_prev = 1'b0;
  endtask

  task automatic drive_period(input int h, input int p);
    push_prev();
    for (int i = 0; i < p; i++) tick(i < h);
    have_prev = 1'b1;
    prev_h = h;
    prev_p = p;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // reset state
    reset = 1'b1;
    repeat (3) tick(1'b0);
    check("rst_high_q", cur_h, 0);
    check("rst_period_q", cur_p, 0);
    check("rst_valid", int'(valid), 0);
    check("rst_stuck", int'(stuck), 0);
    check("rst_level", int'(level), 0);
    reset = 1'b0;
    repeat (2) tick(1'b0);

    // steady 64 / 10 from the generator
    repeat (5) drive_period(10, GEN_PERIOD);

    // duty triangle 1 -> 62 -> 1
    for (int d = 1; d <= 62; d++) drive_period(d, GEN_PERIOD);
    for (int d = 61; d >= 1; d--) drive_period(d, GEN_PERIOD);

    // minimum waveform
    repeat (10) drive_period(1, 2);

    // held high after a rise -> timeout
    push_prev();
    repeat (300) tick(1'b1);
    check("hold_stuck", int'(stuck), 1);
    check("hold_level", int'(level), 1);
    check("hold_stuck_delay", stuck_rise_cyc - last_valid_cyc, 255);
    check("hold_keep_high_q", cur_h, 1);
    check("hold_keep_period_q", cur_p, 2);
    check("hold_pending", exp_q.size(), 0);

    // restart: first rise re-arms only
    repeat (5) tick(1'b0);
    drive_period(10, GEN_PERIOD);
    check("restart_stuck_clear", int'(stuck), 0);
    drive_period(10, GEN_PERIOD);
    drive_period(10, GEN_PERIOD);

    // period 255 is still a measurement, period 256 times out
    drive_period(10, 255);
    drive_period(10, 256);
    repeat (5) tick(1'b0);
    check("p256_stuck", int'(stuck), 1);
    check("p256_keep_period_q", cur_p, 255);
    check("p256_keep_high_q", cur_h, 10);
    have_prev = 1'b0;

    // reset mid-measurement
    drive_period(10, GEN_PERIOD);
    drive_period(20, GEN_PERIOD);
    push_prev();
    repeat (10) tick(1'b1);
    repeat (10) tick(1'b0);
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    check("midrst_high_q", cur_h, 0);
    check("midrst_period_q", cur_p, 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_stuck", int'(stuck), 0);
    check("midrst_level", int'(level), 0);
    repeat (3) drive_period(10, GEN_PERIOD);
    push_prev();
    repeat (3) tick(1'b1);
    repeat (5) tick(1'b0);
    check("final_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_meter.md
# pwm_meter

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It sits directly downstream of the PWM generator, or of any external PWM source routed to a pin, and closes the loop for self-test of the generator. The input is synchronised, both timing counts are taken between consecutive rising edges, and each completed measurement is published with a one-cycle valid strobe. A stuck flag reports a missing or static signal.

## Interface
- CNT_W, 8: width of the high-time counter, the period counter and the result registers; counts saturate at 2^CNT_W-1.
- SYNC_STAGES, 2: number of flip-flops in the input synchroniser; minimum 2.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- pwm_in  in  1  asynchronous PWM input.
- sel  in  1  output select: 0 = high time, 1 = period.
- meas  out  CNT_W  the latched result picked by sel (combinational mux of the result registers).
- valid  out  1  one-cycle pulse when both result registers have been updated.
- stuck  out  1  high when no rising edge has arrived within 2^CNT_W-1 cycles.
- level  out  1  synchronised input level; meaningful while stuck=1.

## Operation
- The synchroniser produces s. s_prev is s delayed by one cycle. A rising edge is rise = s & ~s_prev.
- The block has two states, ARMED and MEASURE.
  - Reset enters ARMED.
  - ARMED + rise: go to MEASURE, load period_cnt=1 and high_cnt=1, no valid.
  - MEASURE + rise:
    - Copy period_cnt into period_q and high_cnt into high_q.
    - Pulse valid the next cycle.
    - Reload both counters to 1.
    - Stay in MEASURE.
  - MEASURE, no rise:
    - period_cnt += 1.
    - high_cnt += s.
    - Both saturate at 2^CNT_W-1.
  - MEASURE when period_cnt == 2^CNT_W-1 and no rise:
    - Set stuck=1 and go to ARMED.
    - No valid pulse.
    - period_q and high_q keep their old values.
- stuck stays set until the next rise, then clears on that cycle's register update.
  - That rise is treated as a first edge: it re-arms only and produces no valid.
- Result semantics: period_q is the number of cycles between two consecutive rising edges. high_q is the number of cycles s was high in that interval. high_q ≤ period_q always holds.
- A rise in the same cycle as period_cnt reaching its maximum is a measurement, not a timeout: valid pulses and stuck stays 0.
- Reset at any time clears state, counters, period_q, high_q, valid, stuck and the synchroniser. meas reads 0 after reset.
- level = s.

## Timing
- Reset values: meas=0, valid=0, stuck=0, level=0.
- Latency: valid is asserted SYNC_STAGES+1 clock edges after the edge that first samples pwm_in high. The results are stable on meas in that same cycle.
- valid width is exactly 1 cycle. It never asserts on two consecutive cycles, because the minimum period is 2 cycles.
- Minimum measurable waveform: period 2, high 1. Narrower pulses may be missed by the synchroniser and are unspecified.
- sel switches meas combinationally in the same cycle. There is no handshake and no back-pressure.
- Results hold until the next valid; the consumer samples them on valid.

## Structure
- Package pwm_pkg holds:
  - the CNT_W default and the counter saturation constant;
  - the meter state enum {ARMED, MEASURE};
  - the generator period constant (64), which the bench uses.
- Sub-module sync_edge (parameter SYNC_STAGES) holds the synchroniser flip-flops and s_prev, and outputs s and rise. The generator self-test reuses it.
- Everything else lives in pwm_meter: FSM, counters, result registers and output mux.

## Test plan
- Reset, then drive period 64 / high 10 → first rise produces no valid; every later valid has period_q=64 and high_q=10 (meas=10 with sel=0, 64 with sel=1).
- Sweep duty 1→62→1 in a triangle, one step per 64-cycle period → each valid reports high_q equal to the previous period's duty and period_q=64, with no missed or extra valids.
- Minimum waveform, period 2 / high 1 → valid on every second cycle, high_q=1, period_q=2.
- Hold pwm_in high for 300 cycles after a rise → stuck=1 and level=1 exactly 255 cycles after the last counter reload; old results are retained and there is no valid. Then restart the toggling → stuck clears at the first rise, and valid returns on the second rise.
- Rise coinciding with period_cnt=255 (period 255) → valid with period_q=255 and stuck=0; period 256 → stuck=1 instead.
- Assert reset mid-measurement for 1 cycle → all outputs 0 the next cycle; the next rise produces no valid (re-arm only).
